// File: rtl/se9_rr_scheduler_if.sv
// se9_rr_scheduler_if: request/grant bundle between leaf instances and the round-robin scheduler
interface se9_rr_scheduler_if #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N_REQ),
    parameter int CW       = $clog2(MAX_HOLD)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             busy;
    logic [CW-1:0]    hold_cnt;
    logic             timeout_pulse;
    modport master (output req, done, input gnt, gnt_id, busy, hold_cnt, timeout_pulse);
    modport slave  (input req, done, output gnt, gnt_id, busy, hold_cnt, timeout_pulse);
endinterface

// File: rtl/se9_rr_scheduler.sv
// se9_rr_scheduler: round-robin owner of one shared slot; grant held until done, withdrawal or timeout,
// followed by a one-cycle release gap
module se9_rr_scheduler #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N_REQ),
    parameter int CW       = $clog2(MAX_HOLD)
) (
    input  logic clk,
    input  logic rst_n,
    se9_rr_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDW-1:0]   r_gnt_id, w_gnt_id_nxt, r_ptr, w_ptr_nxt, w_win;
    logic [CW-1:0]    r_hold, w_hold_nxt;
    logic             r_to, w_to_nxt, w_found, w_own_done, w_own_drop, w_at_max;
    // first requester at or after the pointer, wrapping
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && bus.req[(int'(r_ptr) + k) % N_REQ]) begin
                w_win   = IDW'((int'(r_ptr) + k) % N_REQ);
                w_found = 1'b1;
            end
        end
    end
    assign w_own_done = bus.done[r_gnt_id];
    assign w_own_drop = !bus.req[r_gnt_id];
    assign w_at_max   = r_hold == CW'(MAX_HOLD - 1);
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_hold_nxt   = r_hold;
        w_ptr_nxt    = r_ptr;
        w_to_nxt     = 1'b0;
        case (r_state)
            IDLE: if (|bus.req) begin
                w_state_nxt  = GRANT;
                w_gnt_nxt    = N_REQ'(1) << w_win;
                w_gnt_id_nxt = w_win;
                w_hold_nxt   = '0;
            end
            GRANT: if (w_own_done || w_own_drop || w_at_max) begin
                w_state_nxt = RELEASE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
                w_to_nxt    = !w_own_done && !w_own_drop;
            end else begin
                w_hold_nxt = r_hold + CW'(1);
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = (r_gnt_id == IDW'(N_REQ - 1)) ? '0 : r_gnt_id + IDW'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_hold   <= '0;
            r_ptr    <= '0;
            r_to     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_hold   <= w_hold_nxt;
            r_ptr    <= w_ptr_nxt;
            r_to     <= w_to_nxt;
        end
    end
    assign bus.gnt           = r_gnt;
    assign bus.gnt_id        = r_gnt_id;
    assign bus.busy          = r_state != IDLE;
    assign bus.hold_cnt      = r_hold;
    assign bus.timeout_pulse = r_to;
endmodule

// File: tb/tb_se9_rr_scheduler.sv
// tb_se9_rr_scheduler: directed vectors with hand-computed grants, timeouts and reset behaviour
module tb_se9_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic mon_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   order [6] = '{1, 2, 3, 4, 0, 1};
    se9_rr_scheduler_if #(.N_REQ(5), .MAX_HOLD(16)) bus ();
    se9_rr_scheduler #(.N_REQ(5), .MAX_HOLD(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) if (mon_en) chk("onehot0", 32'($onehot0(bus.gnt)), 1);
    initial begin
        bus.req  = '0;
        bus.done = '0;
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_id", bus.gnt_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_hold", bus.hold_cnt, 0);
        chk("rst_to", bus.timeout_pulse, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        // 1: single requester, done in third grant cycle
        bus.req = 5'b00001;
        step();
        chk("t1_gnt", bus.gnt, 5'b00001);
        chk("t1_busy", bus.busy, 1);
        chk("t1_hold0", bus.hold_cnt, 0);
        step();
        step();
        chk("t1_hold2", bus.hold_cnt, 2);
        bus.done = 5'b00001;
        step();
        chk("t1_rel_gnt", bus.gnt, 0);
        chk("t1_rel_busy", bus.busy, 1);
        chk("t1_rel_to", bus.timeout_pulse, 0);
        bus.done = '0;
        bus.req  = '0;
        step();
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_idle_id", bus.gnt_id, 0);
        // 2: all requesting; pointer at 1 after test 1
        bus.req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2_gnt", bus.gnt, 32'(1) << order[i]);
            chk("t2_id", bus.gnt_id, order[i]);
            bus.done = 5'(1 << order[i]);
            step();
            chk("t2_rel", bus.gnt, 0);
            bus.done = '0;
            if (i == 5) bus.req = '0;
            step();
            chk("t2_idle_busy", bus.busy, 0);
        end
        // 3: req[2] alone, never done -> timeout after 16 grant cycles
        bus.req = 5'b00100;
        step();
        chk("t3_gnt", bus.gnt, 5'b00100);
        chk("t3_hold0", bus.hold_cnt, 0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("t3_hold", bus.hold_cnt, i);
            chk("t3_gnt_held", bus.gnt, 5'b00100);
            chk("t3_no_to", bus.timeout_pulse, 0);
        end
        step();
        chk("t3_rel_gnt", bus.gnt, 0);
        chk("t3_to", bus.timeout_pulse, 1);
        step();
        chk("t3_to_pulse", bus.timeout_pulse, 0);
        chk("t3_idle_busy", bus.busy, 0);
        step();
        chk("t3_regnt", bus.gnt, 5'b00100);
        bus.req = '0;
        step();
        chk("t3_drop_to", bus.timeout_pulse, 0);
        step();
        // 4: owner 3 withdraws at grant cycle 5, next winner wraps to 1
        bus.req = 5'b01010;
        step();
        chk("t4_gnt3", bus.gnt, 5'b01000);
        for (int i = 0; i < 4; i++) step();
        chk("t4_hold4", bus.hold_cnt, 4);
        bus.req = 5'b00010;
        step();
        chk("t4_rel_gnt", bus.gnt, 0);
        chk("t4_rel_to", bus.timeout_pulse, 0);
        step();
        chk("t4_idle_gnt", bus.gnt, 0);
        step();
        chk("t4_gnt1", bus.gnt, 5'b00010);
        chk("t4_id1", bus.gnt_id, 1);
        bus.done = 5'b00010;
        step();
        bus.done = '0;
        bus.req  = '0;
        step();
        // 5: done coincides with hold_cnt==15 -> normal release
        bus.req = 5'b01000;
        step();
        chk("t5_gnt3", bus.gnt, 5'b01000);
        for (int i = 0; i < 15; i++) step();
        chk("t5_hold15", bus.hold_cnt, 15);
        bus.done = 5'b01000;
        step();
        chk("t5_rel_gnt", bus.gnt, 0);
        chk("t5_no_to", bus.timeout_pulse, 0);
        bus.done = '0;
        bus.req  = '0;
        step();
        // 6: reset while owner 4 holds the grant
        bus.req = 5'b10000;
        step();
        chk("t6_gnt4", bus.gnt, 5'b10000);
        chk("t6_id4", bus.gnt_id, 4);
        step();
        bus.req = 5'b11111;
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("t6_rst_gnt", bus.gnt, 0);
        chk("t6_rst_id", bus.gnt_id, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_to", bus.timeout_pulse, 0);
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
        chk("t6_gnt0", bus.gnt, 5'b00001);
        chk("t6_id0", bus.gnt_id, 0);
        step();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
